// File: rtl/cereal_rx_pkg.sv
// Shared definitions for the cereal serial blocks: frame width, FSM encodings
// and the baud divisor computation used by both receiver and transmitter.
package cereal_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/cereal_rx_serial_sync.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 so an idle-high
// line reads idle straight out of reset.
module serial_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cereal_rx.sv
// 8N1 serial receiver: oversampling FSM with a one-entry valid/ack output
// register, framing-error and overrun pulses.
module cereal_rx
    import cereal_rx_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 serialIn,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 good_stop, bad_stop;

    serial_sync u_sync (
        .clk   (sysclk),
        .rst_n (reset),
        .d     (serialIn),
        .q     (rx_s)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // The counter is zeroed on every transition so each state times from entry.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        good_stop   = 1'b0;
        bad_stop    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = ST_START;
            end
            ST_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_idx_nxt = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_LAST) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        good_stop = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        bad_stop  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a stuck-low line
                // is not read as a stream of start bits.
                cnt_nxt = '0;
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (good_stop) begin
                if (!valid || rx_ack) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack && valid) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cereal_rx.sv
// Bench for cereal_rx at 16 clocks per bit: expected bytes are queued as
// frames are sent and checked by a monitor as the receiver delivers them.
module tb_cereal_rx;

    localparam int CPB = 16;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       serialIn;
    logic       rx_ack;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    int checks   = 0;
    int failures = 0;
    int ferr_cnt = 0;
    int ov_cnt   = 0;
    int ev_cnt   = 0;
    int lat      = 0;
    int ev0;

    logic [7:0] exp_q[$];
    logic       valid_q = 1'b0;
    logic [7:0] data_q  = 8'h00;

    cereal_rx #(.CLK_HZ(16), .BAUD(1)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .serialIn  (serialIn),
        .rx_ack    (rx_ack),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        serialIn = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            tick(CPB);
        end
        serialIn = stop_bit;
        tick(CPB);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    // Delivery monitor: a new byte shows as valid rising or data changing
    // while valid stays high.
    always @(negedge sysclk) begin
        if (reset) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) chk("ferr_ov_same_cycle", 32'd1, 32'd0);
            if (valid && (!valid_q || data != data_q)) begin
                ev_cnt++;
                if (exp_q.size() == 0) chk("sb_unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                else chk("sb_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
        end
        valid_q = valid;
        data_q  = data;
    end

    initial begin
        reset    = 1'b0;
        serialIn = 1'b1;
        rx_ack   = 1'b0;
        tick(3);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        tick(3);

        // 1: single byte, latency, ack
        exp_q.push_back(8'h5A);
        fork
            send_byte(8'h5A, 1'b1);
            begin
                lat = 0;
                while (!valid && lat < 200) begin
                    tick(1);
                    lat++;
                end
            end
        join
        chk("t1_latency_in_window", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
        if (lat < 153 || lat > 155) lat = 154;
        chk("t1_valid", {31'd0, valid}, 32'd1);
        ack_pulse();
        chk("t1_valid_after_ack", {31'd0, valid}, 32'd0);
        chk("t1_data_after_ack", {24'd0, data}, 32'h5A);
        tick(5);

        // 2: short glitch rejected
        ferr_cnt = 0; ov_cnt = 0; ev0 = ev_cnt;
        serialIn = 1'b0;
        tick(4);
        serialIn = 1'b1;
        chk("t2_busy_during_glitch", {31'd0, busy}, 32'd1);
        tick(20);
        chk("t2_busy_after", {31'd0, busy}, 32'd0);
        chk("t2_valid", {31'd0, valid}, 32'd0);
        chk("t2_flags", ferr_cnt + ov_cnt, 32'd0);
        chk("t2_no_delivery", ev_cnt - ev0, 32'd0);

        // 3: framing error, held break, then recovery
        ferr_cnt = 0;
        send_byte(8'h3C, 1'b0);
        tick(50);
        chk("t3_ferr_once", ferr_cnt, 32'd1);
        chk("t3_valid", {31'd0, valid}, 32'd0);
        chk("t3_busy_in_break", {31'd0, busy}, 32'd1);
        serialIn = 1'b1;
        tick(4);
        chk("t3_busy_released", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        tick(2);
        chk("t3_valid_81", {31'd0, valid}, 32'd1);
        chk("t3_data_81", {24'd0, data}, 32'h81);
        chk("t3_ferr_total", ferr_cnt, 32'd1);
        ack_pulse();
        tick(3);

        // 4a: back-to-back without ack -> overrun, second byte dropped
        ov_cnt = 0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(2);
        chk("t4a_data", {24'd0, data}, 32'h11);
        chk("t4a_valid", {31'd0, valid}, 32'd1);
        chk("t4a_overrun_once", ov_cnt, 32'd1);
        ack_pulse();
        tick(3);

        // 4b: ack lands in the 0x22 delivery cycle -> replaced, no overrun
        ov_cnt = 0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        fork
            send_byte(8'h22, 1'b1);
            begin
                tick(lat - 1);
                rx_ack = 1'b1;
                tick(1);
                rx_ack = 1'b0;
            end
        join
        tick(2);
        chk("t4b_data", {24'd0, data}, 32'h22);
        chk("t4b_valid", {31'd0, valid}, 32'd1);
        chk("t4b_no_overrun", ov_cnt, 32'd0);
        ack_pulse();
        tick(3);

        // 5: reset mid-frame
        ferr_cnt = 0;
        serialIn = 1'b0;
        tick(CPB);
        serialIn = 1'b1;
        tick(40);
        reset = 1'b0;
        #2;
        chk("t5_rst_data", {24'd0, data}, 32'h00);
        chk("t5_rst_valid", {31'd0, valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(5);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        tick(2);
        chk("t5_data", {24'd0, data}, 32'hA5);
        chk("t5_no_ferr", ferr_cnt, 32'd0);
        ack_pulse();
        tick(3);

        // 6: max-rate stream with each byte acked
        ferr_cnt = 0; ov_cnt = 0; ev0 = ev_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
                send_byte(8'h80, 1'b1);
            end
            begin
                repeat (3 * 10 * CPB + 10) begin
                    tick(1);
                    rx_ack = valid && !rx_ack;
                end
                rx_ack = 1'b0;
            end
        join
        tick(3);
        chk("t6_deliveries", ev_cnt - ev0, 32'd3);
        chk("t6_flags", ferr_cnt + ov_cnt, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
